// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and data-length clamp.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int MIN_NBITS = 5;

  typedef struct packed {
    logic [3:0] nbits;
    logic       two_stop;
  } frame_cfg_t;

  function automatic logic [3:0] clamp_nbits(input logic [3:0] n, input int max_n);
    int v;
    v = int'(n);
    if (v < MIN_NBITS) v = MIN_NBITS;
    else if (v > max_n) v = max_n;
    return v[3:0];
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Oversampling tick counter; bit_end marks the tick that closes a bit period.
module uart_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic clear,
  output logic bit_end
);
  localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OVERSAMPLE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick)  cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  assign bit_end = tick && !clear && (cnt == LAST);
endmodule

// File: rtl/uart_tx_frame.sv
// Per-frame configurable UART transmitter (5..NBITS_DATA data bits, 1/2 stop).
// Parity support is built only when UART_TX_FRAME_PARITY_EN is defined.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int NBITS_DATA = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tick_brg,
  input  logic                  i_tx_start,
  input  logic [NBITS_DATA-1:0] i_data,
  input  logic [3:0]            i_nbits,
  input  logic [1:0]            i_parity_mode,
  input  logic                  i_two_stop,
  output logic                  o_tx,
  output logic                  o_busy,
  output logic                  o_tx_done
);
  logic [2:0]            state, state_n;
  logic [NBITS_DATA-1:0] shreg, shreg_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  frame_cfg_t            cfg, cfg_n;
  logic                  stop_cnt, stop_cnt_n;
  logic                  done_n, tx_n, bit_end;

  uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk     (i_clk),
    .rst     (i_reset),
    .tick    (i_tick_brg),
    .clear   (state == ST_IDLE),
    .bit_end (bit_end)
  );

`ifdef UART_TX_FRAME_PARITY_EN
  logic [1:0] par_mode, par_mode_n;
  logic       par_acc, par_acc_n;
  logic       par_on;
  assign par_on = (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
`else
  logic unused_parity_mode;
  assign unused_parity_mode = ^i_parity_mode;
`endif

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bit_cnt_n  = bit_cnt;
    cfg_n      = cfg;
    stop_cnt_n = stop_cnt;
    done_n     = 1'b0;
`ifdef UART_TX_FRAME_PARITY_EN
    par_mode_n = par_mode;
    par_acc_n  = par_acc;
`endif
    case (state)
      ST_IDLE: if (i_tx_start) begin
        state_n        = ST_START;
        shreg_n        = i_data;
        bit_cnt_n      = '0;
        stop_cnt_n     = 1'b0;
        cfg_n.nbits    = clamp_nbits(i_nbits, NBITS_DATA);
        cfg_n.two_stop = i_two_stop;
`ifdef UART_TX_FRAME_PARITY_EN
        par_mode_n     = i_parity_mode;
        par_acc_n      = 1'b0;
`endif
      end
      ST_START: if (bit_end) state_n = ST_DATA;
      ST_DATA: if (bit_end) begin
        shreg_n   = shreg >> 1;
        bit_cnt_n = bit_cnt + 4'd1;
`ifdef UART_TX_FRAME_PARITY_EN
        par_acc_n = par_acc ^ shreg[0];
        if (bit_cnt_n == cfg.nbits) state_n = par_on ? ST_PARITY : ST_STOP;
`else
        if (bit_cnt_n == cfg.nbits) state_n = ST_STOP;
`endif
      end
`ifdef UART_TX_FRAME_PARITY_EN
      ST_PARITY: if (bit_end) state_n = ST_STOP;
`endif
      ST_STOP: if (bit_end) begin
        if (cfg.two_stop && !stop_cnt) stop_cnt_n = 1'b1;
        else begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Line is registered from next-state values so it moves on the same edge as the state.
  always_comb begin
    tx_n = 1'b1;
    case (state_n)
      ST_START:  tx_n = 1'b0;
      ST_DATA:   tx_n = shreg_n[0];
`ifdef UART_TX_FRAME_PARITY_EN
      ST_PARITY: tx_n = par_acc_n ^ (par_mode == PAR_ODD);
`endif
      default:   tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      cfg       <= '0;
      stop_cnt  <= 1'b0;
      o_tx      <= 1'b1;
      o_tx_done <= 1'b0;
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      bit_cnt   <= bit_cnt_n;
      cfg       <= cfg_n;
      stop_cnt  <= stop_cnt_n;
      o_tx      <= tx_n;
      o_tx_done <= done_n;
    end
  end

`ifdef UART_TX_FRAME_PARITY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      par_mode <= PAR_NONE;
      par_acc  <= 1'b0;
    end else begin
      par_mode <= par_mode_n;
      par_acc  <= par_acc_n;
    end
  end
`endif

  assign o_busy = (state != ST_IDLE);
endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: random frames and ticks, line captured per tick.
module tb_uart_tx_frame;
  localparam int NB = 8;
  localparam int OS = 16;
`ifdef UART_TX_FRAME_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tick = 1'b0;
  logic          start = 1'b0;
  logic [NB-1:0] data = '0;
  logic [3:0]    nbits = 4'd8;
  logic [1:0]    pmode = 2'b00;
  logic          two_stop = 1'b0;
  logic          tx, busy, done;

  uart_tx_frame #(.NBITS_DATA(NB), .OVERSAMPLE(OS)) dut (
    .i_clk(clk), .i_reset(rst), .i_tick_brg(tick), .i_tx_start(start),
    .i_data(data), .i_nbits(nbits), .i_parity_mode(pmode), .i_two_stop(two_stop),
    .o_tx(tx), .o_busy(busy), .o_tx_done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] bits;
    int          len;
  } frame_t;

  frame_t exp_q[$];
  logic   cap[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Expected bit periods of one frame: start, data LSB first, optional parity, stops.
  function automatic frame_t model(input logic [NB-1:0] d, input int n, input logic [1:0] pm,
                                   input logic ts);
    frame_t f;
    int ones;
    if (n < 5) n = 5;
    if (n > NB) n = NB;
    f.bits = '0;
    f.len = 0;
    ones = 0;
    f.bits[f.len] = 1'b0; f.len++;
    for (int i = 0; i < n; i++) begin
      f.bits[f.len] = d[i];
      ones += int'(d[i]);
      f.len++;
    end
    if (PAR_EN && (pm == 2'b01 || pm == 2'b10)) begin
      f.bits[f.len] = ((ones % 2) == 1) ^ (pm == 2'b10);
      f.len++;
    end
    f.bits[f.len] = 1'b1; f.len++;
    if (ts) begin f.bits[f.len] = 1'b1; f.len++; end
    return f;
  endfunction

  always @(negedge clk) begin
    #1 tick = ($urandom_range(0, 2) != 0);
  end

  // Monitor: inputs seen here are the ones the previous rising edge consumed.
  logic prev_busy = 1'b0;
  logic prev_tx = 1'b1;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    frame_t f;
    int errs;
    if (rst) begin
      cap.delete();
      prev_busy = 1'b0;
      prev_tx = 1'b1;
      prev_done = 1'b0;
    end else begin
      if (prev_busy && tick) cap.push_back(prev_tx);
      if (start && !prev_busy) chk("start_latency", {30'd0, busy, tx}, 32'h2);
      if (prev_busy && busy && !tick) chk("line_hold", tx, prev_tx);
      if (!busy) chk("idle_high", tx, 1);
      if (done) begin
        chk("done_one_cycle", prev_done, 0);
        chk("done_not_busy", busy, 0);
        chk("done_has_frame", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          f = exp_q.pop_front();
          chk("frame_ticks", cap.size(), f.len * OS);
          errs = 0;
          for (int i = 0; i < cap.size() && i < f.len * OS; i++)
            if (cap[i] !== f.bits[i / OS]) errs++;
          chk("frame_bits", errs, 0);
        end
        cap.delete();
      end
      prev_busy = busy;
      prev_tx = tx;
      prev_done = done;
    end
  end

  task automatic send(input logic [NB-1:0] d, input logic [3:0] n, input logic [1:0] pm,
                      input logic ts, input bit b2b);
    int guard;
    int gap;
    guard = 0;
    @(negedge clk); #1;
    while (busy && guard < 5000) begin
      start = b2b ? 1'b1 : 1'($urandom_range(0, 1));
      data = NB'($urandom);
      nbits = 4'($urandom);
      pmode = 2'($urandom);
      two_stop = 1'($urandom);
      @(negedge clk); #1;
      guard++;
    end
    chk("idle_timeout", busy, 0);
    if (!b2b) begin
      start = 1'b0;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(negedge clk); #1; end
    end
    data = d; nbits = n; pmode = pm; two_stop = ts; start = 1'b1;
    exp_q.push_back(model(d, int'(n), pm, ts));
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    #1 rst = 1'b0;

    send(8'hA5, 4'd8, 2'b00, 1'b0, 1'b0);
    send(8'h07, 4'd8, 2'b01, 1'b0, 1'b0);
    send(8'h07, 4'd8, 2'b10, 1'b0, 1'b0);
    send(8'hFF, 4'd5, 2'b00, 1'b0, 1'b0);
    send(8'hFF, 4'd2, 2'b00, 1'b0, 1'b0);
    send(8'h5A, 4'd8, 2'b00, 1'b1, 1'b0);
    send(8'hC3, 4'd8, 2'b11, 1'b1, 1'b1);
    send(8'h3C, 4'd15, 2'b01, 1'b0, 1'b1);

    // Abandon a frame mid-DATA: line high and idle at once, no done pulse afterwards.
    send(8'h96, 4'd8, 2'b00, 1'b0, 1'b0);
    repeat (60) begin @(negedge clk); #1; end
    chk("busy_before_reset", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("reset_async_tx", tx, 1);
    chk("reset_async_busy", busy, 0);
    exp_q.delete();
    @(negedge clk); #1 rst = 1'b0;

    for (int k = 0; k < 22; k++)
      send(NB'($urandom), 4'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));

    guard = 0;
    @(negedge clk); #1;
    while (busy && guard < 5000) begin
      @(negedge clk); #1;
      guard++;
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
